// File: rtl/serial_fa_adder.sv
// serial_fa_adder: bit-serial WIDTH-bit adder that pushes both operands LSB-first
// through a single full-adder cell, keeping the carry in a flop between bits,
// and returns the parallel result through a valid/ready handshake.
module serial_fa_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   sa_q,        sa_d;
  logic [WIDTH-1:0]   sb_q,        sb_d;
  logic [WIDTH-1:0]   ps_q,        ps_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic               cout_q,      cout_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               fa_sum_c;
  logic               fa_carry_c;

  // The one full-adder cell shared across all bit positions.
  assign fa_sum_c   = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign fa_carry_c = (sa_q[0] & sb_q[0]) | ((sa_q[0] ^ sb_q[0]) & carry_q);

  // Next-state and datapath updates; handshake flags follow the next state so they stay registered.
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    ps_d        = ps_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ps_d    = {fa_sum_c, ps_q[WIDTH-1:1]};
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        carry_d = fa_carry_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_sum_c, ps_q[WIDTH-1:1]};
          cout_d  = fa_carry_c;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      ps_q        <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      ps_q        <= ps_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_fa_adder.sv
// Testbench for serial_fa_adder: transaction-level reference model checked every
// cycle for a WIDTH=8 and a WIDTH=2 instance, plus literal directed expectations.
module tb_serial_fa_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, cin2 = 1'b0, out_ready2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       in_ready2, out_valid2, cout2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_fa_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8));

  serial_fa_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2));

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted op completes after a fixed number of edges
  // with result a+b+cin, then waits in hold until the consumer takes it.
  bit       m8_idle = 1'b1, m8_hold = 1'b0, m8_cout = 1'b0;
  int       m8_left = 0;
  logic [7:0] m8_sum = '0;
  logic [8:0] m8_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m8_idle <= 1'b1; m8_hold <= 1'b0; m8_left <= 0; m8_sum <= '0; m8_cout <= 1'b0;
    end else if (m8_idle) begin
      if (start8) begin
        m8_idle <= 1'b0;
        m8_left <= 8;
        m8_res  <= 9'(a8) + 9'(b8) + 9'(cin8);
      end
    end else if (m8_left != 0) begin
      m8_left <= m8_left - 1;
      if (m8_left == 1) begin
        m8_hold <= 1'b1;
        {m8_cout, m8_sum} <= m8_res;
      end
    end else if (m8_hold && out_ready8) begin
      m8_hold <= 1'b0;
      m8_idle <= 1'b1;
    end
  end

  bit       m2_idle = 1'b1, m2_hold = 1'b0, m2_cout = 1'b0;
  int       m2_left = 0;
  logic [1:0] m2_sum = '0;
  logic [2:0] m2_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m2_idle <= 1'b1; m2_hold <= 1'b0; m2_left <= 0; m2_sum <= '0; m2_cout <= 1'b0;
    end else if (m2_idle) begin
      if (start2) begin
        m2_idle <= 1'b0;
        m2_left <= 2;
        m2_res  <= 3'(a2) + 3'(b2) + 3'(cin2);
      end
    end else if (m2_left != 0) begin
      m2_left <= m2_left - 1;
      if (m2_left == 1) begin
        m2_hold <= 1'b1;
        {m2_cout, m2_sum} <= m2_res;
      end
    end else if (m2_hold && out_ready2) begin
      m2_hold <= 1'b0;
      m2_idle <= 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u8_in_ready",  33'(in_ready8),  33'(m8_idle));
      chk("u8_out_valid", 33'(out_valid8), 33'(m8_hold));
      chk("u8_sum",       33'(sum8),       33'(m8_sum));
      chk("u8_cout",      33'(cout8),      33'(m8_cout));
      chk("u2_in_ready",  33'(in_ready2),  33'(m2_idle));
      chk("u2_out_valid", 33'(out_valid2), 33'(m2_hold));
      chk("u2_sum",       33'(sum2),       33'(m2_sum));
      chk("u2_cout",      33'(cout2),      33'(m2_cout));
    end
  end

  // Start an op on u8 and wait for out_valid; latency must be 8 edges.
  task automatic launch8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int n;
    n = 0;
    while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("u8_busy_after_start", 33'(in_ready8), 33'(0));
    n = 0;
    while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
    chk("u8_latency", 33'(n), 33'(8));
  endtask

  task automatic release8();
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("u8_idle_after_hold", 33'({in_ready8, out_valid8}), 33'(2'b10));
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input logic [7:0] es, input logic ec);
    launch8(ta, tb, tc);
    chk("u8_sum_lit",  33'(sum8),  33'(es));
    chk("u8_cout_lit", 33'(cout8), 33'(ec));
    release8();
  endtask

  initial begin
    int t[2];
    logic [8:0] r[2];
    int k, n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_state8", 33'({in_ready8, out_valid8, cout8, sum8}), 33'(11'b100_0000_0000));

    // Directed arithmetic cases with hand-computed results.
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // Backpressure: hold result while start and new operands are presented.
    launch8(8'h10, 8'h20, 1'b1);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", 33'({out_valid8, in_ready8, cout8, sum8}), 33'({2'b10, 1'b0, 8'h31}));
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    chk("bp_exit", 33'({in_ready8, out_valid8}), 33'(2'b10));
    @(negedge clk);
    start8 = 1'b0; out_ready8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
    chk("bp_new_sum", 33'({cout8, sum8}), 33'(9'h100));
    release8();

    // Reset during RUN discards the op.
    a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_reset", 33'({in_ready8, out_valid8, cout8, sum8}), 33'(11'b100_0000_0000));
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Back-to-back with start and out_ready held high.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1; out_ready8 = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80;
    k = 0;
    for (int i = 0; i < 60 && k < 2; i++) begin
      @(negedge clk);
      if (out_valid8) begin
        t[k] = i; r[k] = {cout8, sum8}; k++;
      end
    end
    start8 = 1'b0;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("b2b_count", 33'(k), 33'(2));
    if (k == 2) begin
      chk("b2b_res0", 33'(r[0]), 33'(9'h002));
      chk("b2b_res1", 33'(r[1]), 33'(9'h100));
      chk("b2b_spacing", 33'(t[1] - t[0]), 33'(10));
    end

    // WIDTH=2 exhaustive.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          n = 0;
          while (!in_ready2 && n < 20) begin @(negedge clk); n++; end
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          @(negedge clk);
          start2 = 1'b0;
          n = 0;
          while (!out_valid2 && n < 20) begin @(negedge clk); n++; end
          chk("u2_latency", 33'(n), 33'(2));
          chk("u2_result", 33'({cout2, sum2}), 33'(ia + ib + ic));
          out_ready2 = 1'b1;
          @(negedge clk);
          out_ready2 = 1'b0;
        end
      end
    end

    // Random ops on u8 with random backpressure.
    for (int i = 0; i < 40; i++) begin
      launch8(8'($urandom), 8'($urandom), 1'($urandom));
      a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start8 = 1'b0;
      release8();
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/serial_fa_adder.md
Name: serial_fa_adder

Overview:
- Bit-serial WIDTH-bit adder built around the existing one-bit full-adder dataflow cell: sum = a^b^c, carry = (a&b)|((a^b)&c).
- Accepts two parallel operands plus carry-in, feeds them LSB-first through one full-adder cell, and keeps the carry in a flip-flop between bits.
- Sits directly downstream of the full-adder cell. Trades WIDTH cycles of latency for a single adder cell.
- Returns the parallel result through a valid/ready output handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request to add; accepted only on an edge where in_ready=1
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- in_ready  output  1  high only in IDLE
- out_valid  output  1  high only in HOLD
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry

Behaviour:
- Single clock domain; every register updates on rising clk.
- Reset: rst_n=0 sampled on an edge gives state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, internal shift registers and bit counter cleared, carry flop=0. Reset overrides all other inputs, including mid-RUN or mid-HOLD; any partial result is discarded.
- States: IDLE, RUN, HOLD (2-bit encoding; the unused code returns to IDLE).
- IDLE:
  - in_ready=1.
  - On an edge with start=1: load a into shift reg SA, b into SB, cin into carry flop; clear the bit counter; clear the partial-sum reg PS; go to RUN.
  - start=0 keeps the block in IDLE.
- RUN (WIDTH edges):
  - Combinational cell inputs: SA[0], SB[0], carry flop.
  - Each edge: PS shifts right with cell sum into PS[WIDTH-1]; SA and SB shift right (zero fill); carry flop takes cell carry; counter increments.
  - On the edge where counter==WIDTH-1: copy the completed PS (including the bit being shifted in) to sum, copy cell carry to cout, go to HOLD.
  - start is ignored in RUN.
- HOLD:
  - out_valid=1; sum and cout stay stable.
  - On an edge with out_ready=1: go to IDLE. out_valid falls and in_ready rises after that same edge.
  - start is ignored in HOLD, even on the edge where out_ready=1. A new start needs one IDLE cycle.
- Latency: out_valid becomes visible WIDTH edges after the start-accepting edge.
- Throughput with out_ready tied high: one operation per WIDTH+2 cycles.
- sum and cout change only on the RUN-to-HOLD edge or on reset. Between operations they keep the previous result.
- out_ready is ignored in IDLE and RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); there is no overflow flag.
- Operand inputs are sampled only on the accepting edge. Changes to them during RUN or HOLD have no effect.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed in IDLE -> out_valid rises 8 edges later; sum=0x96, cout=0; in_ready=0 from the edge after start until HOLD exits.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: out_ready=0 for 5 cycles in HOLD with start=1 and new operands driven -> sum/cout/out_valid stable; no new op starts. Raise out_ready -> IDLE next edge; the following start computes the new operands correctly.
- Reset mid-run: rst_n=0 on the 3rd RUN edge -> next cycle in_ready=1, out_valid=0, sum=0, cout=0. Then 0x12+0x34, cin=0 -> sum=0x46, cout=0.
- Back-to-back with out_ready=1 and start held high: results for 0x01+0x01 then 0x80+0x80 -> 0x02/0, then 0x00/1; op spacing exactly 10 cycles.
- WIDTH=2, exhaustive over all a, b, cin (32 ops) against a+b+cin reference model -> all match; latency is 2 edges in every case.
